// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants, counter type and window decode helper
// shared by the sync generator and its axis counters.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam logic        SYNC_ACTIVE = 1'b0;

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [CNT_W-1:0] cnt_t;

    // True when lo <= v < hi.
    function automatic logic in_window(input cnt_t v, input int unsigned lo,
                                       input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the pixel/sprite renderer.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic Pixel_tick;
    logic Hsync;
    logic Vsync;
    logic Video_on;
    cnt_t Pixel_x;
    cnt_t Pixel_y;
    logic Line_start;
    logic Frame_start;

    modport master (
        output Pixel_tick, Hsync, Vsync, Video_on,
        output Pixel_x, Pixel_y, Line_start, Frame_start
    );

    modport slave (
        input Pixel_tick, Hsync, Vsync, Video_on,
        input Pixel_x, Pixel_y, Line_start, Frame_start
    );

endinterface

// File: rtl/sync_axis_counter.sv
// One timing axis: wrap counter with enable, registered sync decode of the
// next count, and combinational wrap / next-visible flags for the parent.
module sync_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL,
    parameter int unsigned VISIBLE    = H_VISIBLE,
    parameter int unsigned SYNC_START = H_SYNC_START,
    parameter int unsigned SYNC_END   = H_SYNC_END,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output cnt_t cnt_q,
    output logic sync_q,
    output logic wrap_c,
    output logic visible_nxt_c
);

    cnt_t cnt_d;
    logic sync_d;

    // Compare-before-increment wrap keeps the count inside 0..TOTAL-1.
    always_comb begin
        wrap_c        = en && (cnt_q == CNT_W'(TOTAL - 1));
        cnt_d         = cnt_q;
        if (en) begin
            cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
        end
        sync_d        = in_window(cnt_d, SYNC_START, SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        visible_nxt_c = 32'(cnt_d) < VISIBLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= CNT_W'(TOTAL - 1);
            sync_q <= ~SYNC_ACTIVE;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: edge-detects the divided pixel clock level into a tick
// and drives two axis counters; all timing outputs are registered.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
    parameter logic        SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic           Sys_clock,
    input  logic           Reset_n,
    input  logic           Pixel_clock,
    vga_sync_gen_if.master vif
);

    localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    vga_timing_pkg::cnt_t h_cnt, v_cnt;
    logic h_sync, v_sync;
    logic h_wrap_c, v_wrap_c;
    logic h_vis_nxt_c, v_vis_nxt_c;
    logic tick_c;

    logic pclk_q,        pclk_d;
    logic pixel_tick_q,  pixel_tick_d;
    logic line_start_q,  line_start_d;
    logic frame_start_q, frame_start_d;
    logic video_on_q,    video_on_d;

    sync_axis_counter #(
        .TOTAL       (H_TOT),
        .VISIBLE     (H_VISIBLE),
        .SYNC_START  (H_VISIBLE + H_FRONT),
        .SYNC_END    (H_VISIBLE + H_FRONT + H_SYNC),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_h_axis (
        .clk           (Sys_clock),
        .rst_n         (Reset_n),
        .en            (tick_c),
        .cnt_q         (h_cnt),
        .sync_q        (h_sync),
        .wrap_c        (h_wrap_c),
        .visible_nxt_c (h_vis_nxt_c)
    );

    // Lines advance only on the tick that wraps the horizontal counter.
    sync_axis_counter #(
        .TOTAL       (V_TOT),
        .VISIBLE     (V_VISIBLE),
        .SYNC_START  (V_VISIBLE + V_FRONT),
        .SYNC_END    (V_VISIBLE + V_FRONT + V_SYNC),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_v_axis (
        .clk           (Sys_clock),
        .rst_n         (Reset_n),
        .en            (h_wrap_c),
        .cnt_q         (v_cnt),
        .sync_q        (v_sync),
        .wrap_c        (v_wrap_c),
        .visible_nxt_c (v_vis_nxt_c)
    );

    always_comb begin
        tick_c        = Pixel_clock & ~pclk_q;
        pclk_d        = Pixel_clock;
        pixel_tick_d  = tick_c;
        line_start_d  = h_wrap_c;
        frame_start_d = h_wrap_c & v_wrap_c;
        video_on_d    = h_vis_nxt_c & v_vis_nxt_c;
    end

    always_ff @(posedge Sys_clock) begin
        if (!Reset_n) begin
            pclk_q        <= 1'b0;
            pixel_tick_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            video_on_q    <= 1'b0;
        end else begin
            pclk_q        <= pclk_d;
            pixel_tick_q  <= pixel_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            video_on_q    <= video_on_d;
        end
    end

    assign vif.Pixel_tick  = pixel_tick_q;
    assign vif.Hsync       = h_sync;
    assign vif.Vsync       = v_sync;
    assign vif.Video_on    = video_on_q;
    assign vif.Pixel_x     = h_cnt;
    assign vif.Pixel_y     = v_cnt;
    assign vif.Line_start  = line_start_q;
    assign vif.Frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance plus a shrunken-timing
// instance with SYNC_ACTIVE=1, both checked every cycle against a tick-count model.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic pclk;
    logic check_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    vga_sync_gen_if vif0 ();
    vga_sync_gen_if vif1 ();

    vga_sync_gen dut0 (
        .Sys_clock   (clk),
        .Reset_n     (rst_n),
        .Pixel_clock (pclk),
        .vif         (vif0)
    );

    vga_sync_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .SYNC_ACTIVE (1'b1)
    ) dut1 (
        .Sys_clock   (clk),
        .Reset_n     (rst_n),
        .Pixel_clock (pclk),
        .vif         (vif1)
    );

    always #5 clk = ~clk;

    // Timing tables: [0] default 640x480, [1] small override (15 x 13, sync active high).
    int HV[2] = '{640, 8};
    int HS[2] = '{656, 10};
    int HE[2] = '{752, 13};
    int HT[2] = '{800, 15};
    int VV[2] = '{480, 6};
    int VS[2] = '{490, 8};
    int VE[2] = '{492, 10};
    int VT[2] = '{525, 13};
    bit SA[2] = '{1'b0, 1'b1};

    // Model: number of pixel ticks since reset release fixes the whole raster position.
    int m_n    = 0;
    bit m_prev = 1'b0;
    bit m_tick = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n    = 0;
            m_prev = 1'b0;
            m_tick = 1'b0;
        end else begin
            m_tick = pclk && !m_prev;
            m_prev = pclk;
            if (m_tick) m_n = m_n + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int i, input logic tk, input logic hs, input logic vs,
                              input logic vo, input logic [9:0] px, input logic [9:0] py,
                              input logic ls, input logic fs);
        int x, y, idx;
        logic ehs, evs, evo;
        if (m_n == 0) begin
            x = HT[i] - 1;
            y = VT[i] - 1;
        end else begin
            idx = (m_n - 1) % (HT[i] * VT[i]);
            x   = idx % HT[i];
            y   = idx / HT[i];
        end
        ehs = (x >= HS[i] && x < HE[i]) ? SA[i] : !SA[i];
        evs = (y >= VS[i] && y < VE[i]) ? SA[i] : !SA[i];
        evo = (x < HV[i]) && (y < VV[i]);
        chk($sformatf("d%0d Pixel_x", i), 32'(px), 32'(x));
        chk($sformatf("d%0d Pixel_y", i), 32'(py), 32'(y));
        chk($sformatf("d%0d Hsync", i), 32'(hs), 32'(ehs));
        chk($sformatf("d%0d Vsync", i), 32'(vs), 32'(evs));
        chk($sformatf("d%0d Video_on", i), 32'(vo), 32'(evo));
        chk($sformatf("d%0d Pixel_tick", i), 32'(tk), 32'(m_tick));
        chk($sformatf("d%0d Line_start", i), 32'(ls), 32'(m_tick && x == 0));
        chk($sformatf("d%0d Frame_start", i), 32'(fs), 32'(m_tick && x == 0 && y == 0));
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_inst(0, vif0.Pixel_tick, vif0.Hsync, vif0.Vsync, vif0.Video_on,
                       vif0.Pixel_x, vif0.Pixel_y, vif0.Line_start, vif0.Frame_start);
            check_inst(1, vif1.Pixel_tick, vif1.Hsync, vif1.Vsync, vif1.Video_on,
                       vif1.Pixel_x, vif1.Pixel_y, vif1.Line_start, vif1.Frame_start);
        end
    end

    // Period monitors: line length in Sys_clock cycles, frame length and Vsync width in ticks.
    int cyc = 0;
    int ls_last = 0, ls_prev = 0;
    int tk1 = 0, fs1_last = 0, fs1_per = 0;
    int vs1_acc = 0, vs1_frame = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vif0.Line_start) begin
            ls_prev = ls_last;
            ls_last = cyc;
        end
        if (vif1.Pixel_tick) tk1++;
        if (vif1.Frame_start) begin
            fs1_per   = tk1 - fs1_last;
            fs1_last  = tk1;
            vs1_frame = vs1_acc;
            vs1_acc   = 0;
        end else if (vif1.Pixel_tick && vif1.Vsync) begin
            vs1_acc++;
        end
    end

    task automatic pix_rise();
        pclk = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pix_rest();
        @(posedge clk); #1;
        pclk = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic one_pixel();
        pix_rise();
        pix_rest();
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int hs_low, hs_min, hs_max, hs1_min, hs1_max, vo_off_x, guard, stall_ticks;
        logic [9:0] x1_snap, y1_snap;

        rst_n = 1'b0;
        pclk  = 1'b0;
        @(posedge clk); #1;
        check_en = 1'b1;

        // Reset held 3 cycles while Pixel_clock keeps toggling.
        for (int k = 0; k < 3; k++) begin
            if (k % 2 == 0) pclk = ~pclk;
            @(posedge clk); #1;
        end
        chk("reset x", 32'(vif0.Pixel_x), 32'd799);
        chk("reset y", 32'(vif0.Pixel_y), 32'd524);
        chk("reset hsync", 32'(vif0.Hsync), 32'd1);
        chk("reset vsync", 32'(vif0.Vsync), 32'd1);
        chk("reset video_on", 32'(vif0.Video_on), 32'd0);
        chk("reset tick", 32'(vif0.Pixel_tick), 32'd0);
        chk("reset small x", 32'(vif1.Pixel_x), 32'd14);
        chk("reset small hsync", 32'(vif1.Hsync), 32'd0);
        chk("reset small vsync", 32'(vif1.Vsync), 32'd0);

        pclk  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pix_rise();
        chk("first tick x", 32'(vif0.Pixel_x), 32'd0);
        chk("first tick y", 32'(vif0.Pixel_y), 32'd0);
        chk("first frame_start", 32'(vif0.Frame_start), 32'd1);
        chk("first line_start", 32'(vif0.Line_start), 32'd1);
        chk("first video_on", 32'(vif0.Video_on), 32'd1);
        chk("first small frame_start", 32'(vif1.Frame_start), 32'd1);
        pix_rest();
        chk("frame_start one cycle", 32'(vif0.Frame_start), 32'd0);

        // One full line on the default timing.
        hs_low = 0; hs_min = 9999; hs_max = -1; hs1_min = 9999; hs1_max = -1; vo_off_x = -1;
        for (int p = 1; p <= 800; p++) begin
            pix_rise();
            if (!vif0.Hsync) begin
                hs_low++;
                if (int'(vif0.Pixel_x) < hs_min) hs_min = int'(vif0.Pixel_x);
                if (int'(vif0.Pixel_x) > hs_max) hs_max = int'(vif0.Pixel_x);
            end
            if (vif1.Hsync) begin
                if (int'(vif1.Pixel_x) < hs1_min) hs1_min = int'(vif1.Pixel_x);
                if (int'(vif1.Pixel_x) > hs1_max) hs1_max = int'(vif1.Pixel_x);
            end
            if (vo_off_x < 0 && !vif0.Video_on) vo_off_x = int'(vif0.Pixel_x);
            pix_rest();
        end
        chk("hsync low ticks", 32'(hs_low), 32'd96);
        chk("hsync first x", 32'(hs_min), 32'd656);
        chk("hsync last x", 32'(hs_max), 32'd751);
        chk("video_on falls x", 32'(vo_off_x), 32'd640);
        chk("line period cycles", 32'(ls_last - ls_prev), 32'd3200);
        chk("line 1 y", 32'(vif0.Pixel_y), 32'd1);
        chk("small hsync first x", 32'(hs1_min), 32'd10);
        chk("small hsync last x", 32'(hs1_max), 32'd12);
        chk("small frame period ticks", 32'(fs1_per), 32'd195);
        chk("small vsync active ticks", 32'(vs1_frame), 32'd30);

        // Stall Pixel_clock high at Pixel_x=100.
        guard = 0;
        while (vif0.Pixel_x != 10'd99 && guard < 2000) begin
            one_pixel();
            guard++;
        end
        chk("reach x=99 in budget", 32'(guard < 2000), 32'd1);
        pix_rise();
        x1_snap = vif1.Pixel_x;
        y1_snap = vif1.Pixel_y;
        stall_ticks = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (vif0.Pixel_tick || vif1.Pixel_tick) stall_ticks++;
        end
        chk("stall ticks", 32'(stall_ticks), 32'd0);
        chk("stall x", 32'(vif0.Pixel_x), 32'd100);
        chk("stall y", 32'(vif0.Pixel_y), 32'd1);
        chk("stall small x", 32'(vif1.Pixel_x), 32'(x1_snap));
        chk("stall small y", 32'(vif1.Pixel_y), 32'(y1_snap));
        pclk = 1'b0;
        @(posedge clk); #1;

        // Reset asserted coincident with a tick, mid-frame.
        repeat (37) one_pixel();
        pclk  = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset x", 32'(vif0.Pixel_x), 32'd799);
        chk("midreset y", 32'(vif0.Pixel_y), 32'd524);
        chk("midreset tick", 32'(vif0.Pixel_tick), 32'd0);
        chk("midreset line_start", 32'(vif0.Line_start), 32'd0);
        chk("midreset small y", 32'(vif1.Pixel_y), 32'd12);
        @(posedge clk); #1;
        pclk  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pix_rise();
        chk("post-reset x", 32'(vif0.Pixel_x), 32'd0);
        chk("post-reset y", 32'(vif0.Pixel_y), 32'd0);
        chk("post-reset frame_start", 32'(vif0.Frame_start), 32'd1);
        chk("post-reset small frame_start", 32'(vif1.Frame_start), 32'd1);
        pix_rest();

        repeat (300) one_pixel();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
